bridge_gate_scheduler: RTL and testbench
========================================

// Module: bridge_gate_scheduler
// PURPOSE
//  Half-bridge gate scheduler. Grants the high-side and low-side gate requests
//  with guaranteed mutual exclusion, DEADTIME insertion and MIN_ON enforcement.
//  Consumes the shoot-through detector's stretched fault pulse. Forces both
//  gates off, holds a retriggerable fault window, and latches a lockout after
//  FAULT_LIMIT events.
// PARAMETERS
//  CNT_W       8    timer width; must hold max(DEADTIME, MIN_ON, FAULT_HOLD)
//  DEADTIME    10   cycles both gates low between any gate turn-off and next turn-on
//  MIN_ON      4    minimum cycles a granted gate stays high
//  FAULT_HOLD  200  cycles both gates forced low after the last st_det
//  FAULT_LIMIT 3    fault count that causes permanent lockout (1..2^FC_W-1)
//  FC_W        4    fault counter width
// PORTS
//  clk        in   1     system clock, all logic on posedge
//  rst_n      in   1     asynchronous active-low reset
//  hi_req     in   1     high-side on request (synchronous, level)
//  lo_req     in   1     low-side on request (synchronous, level)
//  st_det     in   1     shoot-through detected (synchronous level/pulse)
//  fault_clr  in   1     clears lockout and fault count (1-cycle pulse)
//  hi_gate    out  1     high-side gate drive, registered
//  lo_gate    out  1     low-side gate drive, registered
//  conflict   out  1     both requests seen at a grant decision, registered
//  fault      out  1     high while in FAULT_HOLD window, registered
//  lockout    out  1     high while locked, registered
//  fault_cnt  out  FC_W  saturating count of st_det entries since last clear
// BEHAVIOUR
//  Reset (rst_n=0): state=DT, timer=0, fault_cnt=0, every output 0.
//  States: DT, IDLE, HI_ON, LO_ON, FAULT, LOCK. The gates are high only in HI_ON and LO_ON.
//  DT: gates 0. The timer counts 0..DEADTIME-1. At the last count the block goes to IDLE.
//    Result: after reset, after every turn-off and after FAULT, both gates are 0 for
//    at least DEADTIME cycles.
//  IDLE: only hi_req high -> HI_ON, and hi_gate=1 on the next edge (1-cycle latency).
//    Only lo_req high -> LO_ON the same way.
//    Both requests high -> stay in IDLE with conflict=1. conflict=0 in every other cycle.
//  HI_ON/LO_ON: the timer counts the on cycles. The requests of the other side are ignored.
//    The state exits to DT when (on cycles >= MIN_ON) and the own request is 0.
//    The gate falls on that edge.
//    A request that drops before MIN_ON is honoured at MIN_ON. The gate is never shorter.
//  Back-to-back handover: hi_req falls and lo_req is already high.
//    lo_gate rises exactly DEADTIME+1 cycles after hi_gate falls (DT, then the IDLE decision).
//  st_det=1 in any state except LOCK: next edge -> FAULT, both gates 0, fault=1, timer=0.
//    fault_cnt increments and saturates at 2^FC_W-1.
//  FAULT: retriggerable. st_det=1 restarts the timer at 0 and increments fault_cnt again.
//    When the timer reaches FAULT_HOLD-1 with no st_det, fault drops.
//    Exit: fault_cnt >= FAULT_LIMIT -> LOCK. Otherwise -> DT.
//  LOCK: gates 0, lockout=1. st_det is ignored.
//    fault_clr -> DT, lockout=0, fault_cnt=0 on the same edge.
//  fault_clr outside LOCK and FAULT: fault_cnt=0 and the state is unaffected.
//    In FAULT, fault_clr is ignored.
//  Simultaneous events: st_det beats fault_clr, requests and timer expiry in the same cycle.
//  Invariant: hi_gate & lo_gate is never 1. Any violation is a design error.
//  rst_n asserted mid-operation: outputs go to 0 immediately (async).
//    After release the block restarts in DT.
//  The timer never wraps. It is reset on every state entry and saturates.
// TESTING (DEADTIME=10, MIN_ON=4, FAULT_HOLD=20, FAULT_LIMIT=3)
//  1. Reset release, hi_req=1 from cycle 0 -> hi_gate rises on cycle 11, never earlier.
//  2. In HI_ON, hi_req pulses 1 cycle -> hi_gate is high for exactly 4 cycles, then 10 dead cycles.
//  3. hi_gate high, lo_req=1, hi_req falls -> lo_gate rises 11 cycles after hi_gate falls; never overlap.
//  4. In IDLE, hi_req=lo_req=1 -> no gate, conflict=1. Drop lo_req -> hi_gate rises next cycle.
//  5. st_det pulse while lo_gate high -> lo_gate 0 next cycle, fault=1 for 20 cycles, fault_cnt=1, then DT.
//  6. Three st_det pulses (one retriggers FAULT) -> fault_cnt=3, LOCK, lockout=1.
//     The requests are ignored. fault_clr -> lockout=0, fault_cnt=0, gates 0 for 10 cycles.

Source files
------------

// File: rtl/bridge_gate_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_gate_scheduler
//  Purpose  : Half-bridge gate scheduler. Grants high-side / low-side gate
//             requests with mutual exclusion, dead-time insertion and a
//             minimum on-time. A shoot-through detection forces both gates
//             off for a retriggerable hold window; after FAULT_LIMIT faults
//             the block locks out until fault_clr.
//  Ports    : clk        - system clock, rising edge
//             rst_n      - asynchronous active-low reset
//             hi_req     - high-side on request (level)
//             lo_req     - low-side on request (level)
//             st_det     - shoot-through detected (level/pulse)
//             fault_clr  - clears lockout and fault count (1-cycle pulse)
//             hi_gate    - high-side gate drive (registered)
//             lo_gate    - low-side gate drive (registered)
//             conflict   - both requests present at a grant decision
//             fault      - high while the fault hold window is active
//             lockout    - high while locked out
//             fault_cnt  - saturating count of fault entries since last clear
//  Revision : 1.0 - initial release
// ============================================================================
module bridge_gate_scheduler #(
  parameter int CNT_W       = 8,
  parameter int DEADTIME    = 10,
  parameter int MIN_ON      = 4,
  parameter int FAULT_HOLD  = 200,
  parameter int FAULT_LIMIT = 3,
  parameter int FC_W        = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hi_req,
  input  logic            lo_req,
  input  logic            st_det,
  input  logic            fault_clr,
  output logic            hi_gate,
  output logic            lo_gate,
  output logic            conflict,
  output logic            fault,
  output logic            lockout,
  output logic [FC_W-1:0] fault_cnt
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [2:0] S_DT    = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_HI_ON = 3'd2;
  localparam logic [2:0] S_LO_ON = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;
  localparam logic [2:0] S_LOCK  = 3'd5;

  // --------------------------------------------------------------------------
  // Timer / counter constants
  // --------------------------------------------------------------------------
  localparam logic [CNT_W-1:0] TMR_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMR_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DT_LAST   = CNT_W'(DEADTIME - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FAULT_HOLD - 1);
  localparam logic [CNT_W:0]   ON_ONE    = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   MIN_ON_W  = (CNT_W+1)'(MIN_ON);
  localparam logic [FC_W-1:0]  FC_ONE    = FC_W'(1);
  localparam logic [FC_W-1:0]  FC_MAX    = {FC_W{1'b1}};
  localparam logic [FC_W-1:0]  FC_LIMIT  = FC_W'(FAULT_LIMIT);

  // --------------------------------------------------------------------------
  // Internal state
  // --------------------------------------------------------------------------
  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_nxt;
  logic [CNT_W-1:0] timer_inc;
  logic [CNT_W:0]   on_cycles;
  logic             on_done;
  logic [FC_W-1:0]  cnt_nxt;
  logic [FC_W-1:0]  cnt_inc;
  logic             conflict_nxt;

  // Timer saturates instead of wrapping.
  assign timer_inc = (timer == TMR_MAX) ? timer : (timer + TMR_ONE);

  // The timer holds the number of completed on-cycles minus one while a gate
  // is high (it is zero on the entry edge), so the current decision edge
  // closes on-cycle number timer+1. Extra bit avoids overflow at saturation.
  assign on_cycles = {1'b0, timer} + ON_ONE;
  assign on_done   = (on_cycles >= MIN_ON_W);

  // Fault counter saturates at all-ones.
  assign cnt_inc = (fault_cnt == FC_MAX) ? fault_cnt : (fault_cnt + FC_ONE);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer_inc;
    cnt_nxt      = fault_cnt;
    conflict_nxt = 1'b0;

    if (st_det && (state != S_LOCK)) begin
      // Shoot-through has priority over every other event, including
      // fault_clr, requests and timer expiry. Re-entry from FAULT restarts
      // the hold window.
      state_nxt = S_FAULT;
      timer_nxt = '0;
      cnt_nxt   = cnt_inc;
    end else begin
      case (state)
        S_DT: begin
          if (fault_clr) begin
            cnt_nxt = '0;
          end
          if (timer == DT_LAST) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
          end
        end

        S_IDLE: begin
          if (fault_clr) begin
            cnt_nxt = '0;
          end
          if (hi_req && !lo_req) begin
            state_nxt = S_HI_ON;
            timer_nxt = '0;
          end else if (lo_req && !hi_req) begin
            state_nxt = S_LO_ON;
            timer_nxt = '0;
          end else if (hi_req && lo_req) begin
            conflict_nxt = 1'b1;
          end
        end

        S_HI_ON: begin
          if (fault_clr) begin
            cnt_nxt = '0;
          end
          // lo_req is deliberately not looked at while high side is on.
          if (on_done && !hi_req) begin
            state_nxt = S_DT;
            timer_nxt = '0;
          end
        end

        S_LO_ON: begin
          if (fault_clr) begin
            cnt_nxt = '0;
          end
          if (on_done && !lo_req) begin
            state_nxt = S_DT;
            timer_nxt = '0;
          end
        end

        S_FAULT: begin
          // fault_clr has no effect inside the hold window.
          if (timer == HOLD_LAST) begin
            state_nxt = (fault_cnt >= FC_LIMIT) ? S_LOCK : S_DT;
            timer_nxt = '0;
          end
        end

        S_LOCK: begin
          timer_nxt = timer;
          if (fault_clr) begin
            state_nxt = S_DT;
            timer_nxt = '0;
            cnt_nxt   = '0;
          end
        end

        default: begin
          // Illegal encoding: fall back to the safe dead-time state.
          state_nxt = S_DT;
          timer_nxt = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State and registered outputs. Gates are decoded from a single next-state
  // value, so both can never be high in the same cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_DT;
      timer     <= '0;
      fault_cnt <= '0;
      hi_gate   <= 1'b0;
      lo_gate   <= 1'b0;
      conflict  <= 1'b0;
      fault     <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      fault_cnt <= cnt_nxt;
      hi_gate   <= (state_nxt == S_HI_ON);
      lo_gate   <= (state_nxt == S_LO_ON);
      conflict  <= conflict_nxt;
      fault     <= (state_nxt == S_FAULT);
      lockout   <= (state_nxt == S_LOCK);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bridge_gate_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bridge_gate_scheduler
//  Purpose  : Directed self-checking bench for bridge_gate_scheduler with
//             DEADTIME=10, MIN_ON=4, FAULT_HOLD=20, FAULT_LIMIT=3.
//             Expected output vectors {hi,lo,conflict,fault,lockout,cnt}
//             are queued with each stimulus step and popped when the DUT
//             response is sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bridge_gate_scheduler;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       hi_req    = 1'b0;
  logic       lo_req    = 1'b0;
  logic       st_det    = 1'b0;
  logic       fault_clr = 1'b0;
  logic       hi_gate;
  logic       lo_gate;
  logic       conflict;
  logic       fault;
  logic       lockout;
  logic [3:0] fault_cnt;

  bridge_gate_scheduler #(
    .CNT_W      (8),
    .DEADTIME   (10),
    .MIN_ON     (4),
    .FAULT_HOLD (20),
    .FAULT_LIMIT(3),
    .FC_W       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hi_req    (hi_req),
    .lo_req    (lo_req),
    .st_det    (st_det),
    .fault_clr (fault_clr),
    .hi_gate   (hi_gate),
    .lo_gate   (lo_gate),
    .conflict  (conflict),
    .fault     (fault),
    .lockout   (lockout),
    .fault_cnt (fault_cnt)
  );

  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {hi_gate, lo_gate, conflict, fault, lockout, fault_cnt};

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // flags = {hi, lo, conflict, fault, lockout}
  function automatic logic [8:0] ev(input logic [4:0] flags, input logic [3:0] n);
    return {flags, n};
  endfunction

  task automatic compare_front();
    exp_t e;
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e.exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b required %b", e.tag, obs, e.exp);
    end
  endtask

  // Queue expectation, advance one clock, sample 1 time unit after the edge.
  task automatic cyc(input string tag, input logic [8:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  // Queue expectation and sample without waiting for a clock edge.
  task automatic now_chk(input string tag, input logic [8:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
    #1;
    compare_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---------------- Reset, then hi_req held from cycle 0 ----------------
    hi_req = 1'b1;
    repeat (2) cyc("reset", ev(5'b00000, 4'd0));
    rst_n = 1'b1;
    repeat (10) cyc("t1_dead", ev(5'b00000, 4'd0));
    cyc("t1_rise", ev(5'b10000, 4'd0));

    // ---------------- Short request honoured for MIN_ON ----------------
    hi_req = 1'b0;
    repeat (3) cyc("t2_min_on", ev(5'b10000, 4'd0));
    cyc("t2_fall", ev(5'b00000, 4'd0));
    repeat (9) cyc("t2_dead", ev(5'b00000, 4'd0));
    cyc("t2_idle", ev(5'b00000, 4'd0));

    // ---------------- Handover high -> low ----------------
    hi_req = 1'b1;
    cyc("t3_hi_rise", ev(5'b10000, 4'd0));
    lo_req = 1'b1;
    repeat (5) cyc("t3_hi_hold", ev(5'b10000, 4'd0));
    hi_req = 1'b0;
    cyc("t3_hi_fall", ev(5'b00000, 4'd0));
    repeat (10) cyc("t3_dead", ev(5'b00000, 4'd0));
    cyc("t3_lo_rise", ev(5'b01000, 4'd0));
    cyc("t3_lo_hold", ev(5'b01000, 4'd0));

    // ---------------- Shoot-through while low side on ----------------
    st_det = 1'b1;
    lo_req = 1'b0;
    cyc("t5_fault_in", ev(5'b00010, 4'd1));
    st_det = 1'b0;
    repeat (19) cyc("t5_hold", ev(5'b00010, 4'd1));
    cyc("t5_exit", ev(5'b00000, 4'd1));
    repeat (9) cyc("t5_dead", ev(5'b00000, 4'd1));
    cyc("t5_idle", ev(5'b00000, 4'd1));

    // ---------------- Conflict in IDLE ----------------
    hi_req = 1'b1;
    lo_req = 1'b1;
    repeat (2) cyc("t4_conflict", ev(5'b00100, 4'd1));
    lo_req = 1'b0;
    cyc("t4_hi_rise", ev(5'b10000, 4'd1));

    // fault_clr outside FAULT/LOCK: count cleared, gate undisturbed
    fault_clr = 1'b1;
    cyc("clr_in_on", ev(5'b10000, 4'd0));
    fault_clr = 1'b0;
    cyc("clr_in_on_hold", ev(5'b10000, 4'd0));

    // ---------------- Three faults -> lockout ----------------
    st_det = 1'b1;
    cyc("t6_det1", ev(5'b00010, 4'd1));
    st_det = 1'b0;
    repeat (4) cyc("t6_hold1", ev(5'b00010, 4'd1));
    st_det = 1'b1;
    cyc("t6_retrig", ev(5'b00010, 4'd2));
    st_det = 1'b0;
    for (int i = 0; i < 19; i++) begin
      fault_clr = (i == 3);
      cyc("t6_hold2", ev(5'b00010, 4'd2));
    end
    fault_clr = 1'b0;
    cyc("t6_exit2", ev(5'b00000, 4'd2));
    st_det = 1'b1;
    cyc("t6_det3", ev(5'b00010, 4'd3));
    st_det = 1'b0;
    repeat (19) cyc("t6_hold3", ev(5'b00010, 4'd3));
    cyc("t6_lock", ev(5'b00001, 4'd3));
    lo_req = 1'b1;
    repeat (3) cyc("t6_locked", ev(5'b00001, 4'd3));
    lo_req = 1'b0;
    st_det = 1'b1;
    cyc("t6_det_in_lock", ev(5'b00001, 4'd3));
    st_det = 1'b0;
    fault_clr = 1'b1;
    cyc("t6_clear", ev(5'b00000, 4'd0));
    fault_clr = 1'b0;
    repeat (10) cyc("t6_dead", ev(5'b00000, 4'd0));
    cyc("t6_rise", ev(5'b10000, 4'd0));

    // ---------------- Asynchronous reset mid-operation ----------------
    rst_n = 1'b0;
    now_chk("async_rst", ev(5'b00000, 4'd0));
    cyc("rst_hold", ev(5'b00000, 4'd0));
    rst_n = 1'b1;
    repeat (10) cyc("rst_dead", ev(5'b00000, 4'd0));
    cyc("rst_rise", ev(5'b10000, 4'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
